fp_add_issue: RTL and testbench

Operand-issue and result-capture stage placed directly upstream of the FP32 adder (`addsub`). It accepts operand pairs over a valid/ready handshake, applies the optional subtract sign flip, and resolves IEEE special cases (NaN, Inf, zero/denormal) locally. It then drives registered operands into the combinational adder, samples the adder result after a fixed settle latency, and presents one result per transaction downstream with backpressure.

---
 rtl/fp_pkg.sv | 15 +
 rtl/fp_classify.sv | 13 +
 rtl/fp_add_issue.sv | 92 +++++++++
 tb/tb_fp_add_issue.sv | 137 +++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: shared FP32 types, constants, flag indices and issue-stage state encoding
package fp_pkg;
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;
  localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
  localparam logic [7:0]  FP_EXP_MAX = 8'hFF;
  localparam int FLAG_BYPASS = 0;
  localparam int FLAG_NAN    = 1;
  localparam int FLAG_INF    = 2;
  localparam int FLAG_OVF    = 3;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} issue_state_e;
endpackage

// File: rtl/fp_classify.sv
// fp_classify: flags an FP32 value as zero (denormals flushed), infinity or NaN
module fp_classify
  import fp_pkg::*;
(
  input  fp32_t x,
  output logic  is_zero,
  output logic  is_inf,
  output logic  is_nan
);
  assign is_zero = x.exp == 8'h00;
  assign is_inf  = x.exp == FP_EXP_MAX && x.frac == '0;
  assign is_nan  = x.exp == FP_EXP_MAX && x.frac != '0;
endmodule

// File: rtl/fp_add_issue.sv
// fp_add_issue: operand issue / result capture around a combinational FP32 adder, with local special-case bypass
module fp_add_issue
  import fp_pkg::*;
#(
  parameter int ADD_LAT = 1
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_sub,
  output logic [31:0] op1,
  output logic [31:0] op2,
  input  logic [31:0] add_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [3:0]  out_flags
);
  issue_state_e state;
  logic [3:0]  cnt;
  logic [31:0] a, b;
  logic        a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic        any_nan, inf_clash, byp;
  logic [31:0] byp_res;
  logic [3:0]  byp_flags;
  logic        sat;
  assign a = in_a;
  assign b = {in_b[31] ^ in_sub, in_b[30:0]};
  fp_classify u_cls_a (.x(a), .is_zero(a_zero), .is_inf(a_inf), .is_nan(a_nan));
  fp_classify u_cls_b (.x(b), .is_zero(b_zero), .is_inf(b_inf), .is_nan(b_nan));
  assign in_ready = n_rst && state == IDLE;
  assign sat      = add_result[30:23] == FP_EXP_MAX;
  always_comb begin
    any_nan   = a_nan | b_nan;
    inf_clash = a_inf & b_inf & (a[31] ^ b[31]);
    byp       = any_nan | a_inf | b_inf | a_zero | b_zero;
    byp_res   = (any_nan | inf_clash) ? FP_QNAN :
                a_inf                 ? a :
                b_inf                 ? b :
                (a_zero & b_zero)     ? {a[31] & b[31], 31'd0} :
                a_zero                ? b : a;
    byp_flags              = '0;
    byp_flags[FLAG_BYPASS] = byp;
    byp_flags[FLAG_NAN]    = any_nan | inf_clash;
    byp_flags[FLAG_INF]    = ~any_nan & (a_inf | b_inf);
  end
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      op1        <= '0;
      op2        <= '0;
      out_result <= '0;
      out_flags  <= '0;
      out_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          if (byp) begin
            out_result <= byp_res;
            out_flags  <= byp_flags;
            out_valid  <= 1'b1;
            state      <= RESP;
          end else begin
            op1   <= a;
            op2   <= b;
            cnt   <= 4'(ADD_LAT);
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            // an all-ones exponent from the adder is reported as a saturated infinity
            out_result <= sat ? {add_result[31], FP_EXP_MAX, 23'd0} : add_result;
            out_flags  <= sat ? 4'((1 << FLAG_INF) | (1 << FLAG_OVF)) : 4'd0;
            out_valid  <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_add_issue.sv
// tb_fp_add_issue: directed vector table plus backpressure and mid-transaction reset sequences
module tb_fp_add_issue;
  localparam int LAT = 2;
  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_sub = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [31:0] add_result = '0;
  logic        in_ready, out_valid;
  logic [31:0] op1, op2, out_result;
  logic [3:0]  out_flags;
  fp_add_issue #(.ADD_LAT(LAT)) dut (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .op1(op1), .op2(op2),
    .add_result(add_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] add;
    logic [31:0] res;
    logic [3:0]  flags;
    logic        byp;
  } vec_t;
  vec_t vecs[15];
  int checks = 0;
  int errors = 0;
  logic [31:0] p1 = '0;
  logic [31:0] p2 = '0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic txn(input vec_t v, input int hold);
    int n;
    logic [31:0] bp;
    bp = {v.b[31] ^ v.sub, v.b[30:0]};
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_a = v.a; in_b = v.b; in_sub = v.sub; add_result = v.add;
    in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; in_a = 32'h3F80_0001; in_b = 32'h3F80_0002; in_sub = ~v.sub;
    chk("op1", op1, v.byp ? p1 : v.a);
    chk("op2", op2, v.byp ? p2 : bp);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), v.byp ? 32'd0 : 32'(LAT));
    chk("result", out_result, v.res);
    chk("flags", 32'(out_flags), 32'(v.flags));
    chk("in_ready_resp", 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_result", out_result, v.res);
      chk("hold_flags", 32'(out_flags), 32'(v.flags));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_op1", op1, v.byp ? p1 : v.a);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_drop", 32'(out_valid), 32'd0);
    if (!v.byp) begin
      p1 = v.a;
      p2 = bp;
    end
  endtask
  initial begin
    vecs[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 32'h40400000, 4'h0, 1'b0};
    vecs[1]  = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 32'h40000000, 4'h0, 1'b0};
    vecs[2]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h12345678, 32'h7FC00000, 4'h7, 1'b1};
    vecs[3]  = '{32'h00000000, 32'hC0400000, 1'b0, 32'h12345678, 32'hC0400000, 4'h1, 1'b1};
    vecs[4]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h12345678, 32'h80000000, 4'h1, 1'b1};
    vecs[5]  = '{32'h7F000000, 32'h7F000000, 1'b0, 32'h7F800005, 32'h7F800000, 4'hC, 1'b0};
    vecs[6]  = '{32'h7F800001, 32'h3F800000, 1'b0, 32'h12345678, 32'h7FC00000, 4'h3, 1'b1};
    vecs[7]  = '{32'h7F800000, 32'h7F800000, 1'b0, 32'h12345678, 32'h7F800000, 4'h5, 1'b1};
    vecs[8]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h12345678, 32'h7FC00000, 4'h7, 1'b1};
    vecs[9]  = '{32'h3F800000, 32'hFF800000, 1'b0, 32'h12345678, 32'hFF800000, 4'h5, 1'b1};
    vecs[10] = '{32'h40400000, 32'h80000000, 1'b0, 32'h12345678, 32'h40400000, 4'h1, 1'b1};
    vecs[11] = '{32'h00000001, 32'h3F800000, 1'b0, 32'h12345678, 32'h3F800000, 4'h1, 1'b1};
    vecs[12] = '{32'h00000000, 32'h80000000, 1'b0, 32'h12345678, 32'h00000000, 4'h1, 1'b1};
    vecs[13] = '{32'h3F800000, 32'h00000000, 1'b1, 32'h12345678, 32'h3F800000, 4'h1, 1'b1};
    vecs[14] = '{32'hFF000000, 32'h7F000000, 1'b1, 32'hFF900000, 32'hFF800000, 4'hC, 1'b0};
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_op1", op1, 32'd0);
    chk("rst_op2", op2, 32'd0);
    chk("rst_result", out_result, 32'd0);
    chk("rst_flags", 32'(out_flags), 32'd0);
    n_rst = 1'b1;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 15; i++) txn(vecs[i], 0);
    txn(vecs[0], 5);
    txn(vecs[3], 5);
    @(negedge clk);
    in_a = vecs[1].a; in_b = vecs[1].b; in_sub = vecs[1].sub; add_result = vecs[1].add;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("wait_op2", op2, 32'hBF800000);
    n_rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_op1", op1, 32'd0);
    chk("mid_rst_op2", op2, 32'd0);
    chk("mid_rst_result", out_result, 32'd0);
    chk("mid_rst_flags", 32'(out_flags), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    n_rst = 1'b1;
    p1 = '0;
    p2 = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_pulse", 32'(out_valid), 32'd0);
    end
    txn(vecs[0], 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
